uart_rx_si: RTL and testbench
=============================

Name: uart_rx_si

Overview:
UART receiver that feeds the configuration-register receive path. It deserialises an asynchronous 8N1 serial line into bytes. Each byte is presented on a single-entry simple-interface holding register (rx_data / rx_rdy / rx_ack). The configuration-register receive block consumes this holding register directly, and frame and overrun errors are flagged as one-cycle pulses.

Parameters:
- RX_DATA_WIDTH, 8, bits per frame (LSB first); must equal the consumer's RX_DATA_WIDTH.
- BAUD_DIV, 104, clk cycles per bit; legal range >= 4; internal counter width $clog2(BAUD_DIV).

Ports:
- clk  in  1  fpga clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset); deassertion synchronous to clk.
- rx_i  in  1  serial line; idles high; asynchronous to clk.
- rx_data  out  RX_DATA_WIDTH  received byte; valid while rx_rdy=1.
- rx_rdy  out  1  holding register full.
- rx_ack  in  1  consumer acknowledge; ignored when rx_rdy=0.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled 0.
- overrun_o  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

Behaviour:
- Reset values: rx_data=0, rx_rdy=0, frame_err_o=0, overrun_o=0, synchroniser flops=1, state=IDLE, bit counter=0, baud counter=0.
- Synchronisation:
  - rx_i passes through a 2-flop synchroniser (reset value 1).
  - All decisions use the synchronised value rx_s.
  - Sampling therefore lags the pin by 2 cycles.
- State machine:
  - IDLE: on rx_s=0, clear the baud counter and go to START.
  - START: at baud count BAUD_DIV/2-1 (integer division), sample rx_s.
    - 1 -> false start, return to IDLE, no error pulse.
    - 0 -> clear counter and bit index, go to DATA.
  - DATA: at each baud count BAUD_DIV-1, shift rx_s into the shift register from the MSB side (LSB-first line order).
    - Restart the counter after each sample.
    - After RX_DATA_WIDTH samples, go to STOP.
  - STOP: at count BAUD_DIV-1, sample rx_s.
    - 1 -> frame valid, commit the byte, go to IDLE.
    - 0 -> frame_err_o=1 for one cycle, byte discarded, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. A held-low line yields exactly one frame_err_o pulse.
- Commit, holding register and handshake:
  - On commit with rx_rdy=0: next cycle rx_data=byte and rx_rdy=1. Latency is 1 clk after the stop-sample edge.
  - rx_ack with rx_rdy=1 clears rx_rdy the next cycle; rx_data holds its value.
  - rx_ack with rx_rdy=0 has no effect.
  - Commit with rx_rdy=1 and rx_ack=0 in the same cycle: new byte dropped, old byte kept, overrun_o pulses once.
  - Commit with rx_rdy=1 and rx_ack=1 in the same cycle: new byte loaded, rx_rdy stays 1, no overrun.
- Back-to-back frames: a start bit immediately after the stop sample is detected from IDLE without loss. Stop-bit sampling at mid-bit leaves half a bit of slack.
- Reset mid-frame: all state returns to reset values immediately; the partial byte is lost. After reset release, a line still low is treated as a start edge in IDLE. The bench avoids releasing reset mid-frame.
- Error pulses never assert simultaneously with each other.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; it samples one bit at count BAUD_DIV-1.
  - Even parity over data plus parity bit is required.
  - Mismatch -> the byte is discarded after the stop bit, and a new output parity_err_o (1 bit) pulses for one cycle at the stop sample. A stop=0 check still takes precedence (frame_err_o only).
- When undefined: no PARITY state and no parity_err_o port; frame is 8N1.

Decomposition:
- HDL_defines.v gains:
  - `__UART_BAUD_DIV (default divider used by top level).
  - State encodings `__URX_IDLE, `__URX_START, `__URX_DATA, `__URX_PARITY, `__URX_STOP, `__URX_BREAK (3-bit).
- One natural sub-module: sync_2ff (parameterised reset value), reused for the other asynchronous inputs in the design.

Test Plan:
- BAUD_DIV=16. Send 0xA5 with rx_ack tied 0 -> rx_rdy=1 exactly 1 cycle after the stop-sample edge, rx_data=0xA5, no error pulses.
- Send 0x3C, then 0x81 back-to-back with no ack -> rx_data stays 0x3C, one overrun_o pulse at the second commit. Ack, then send 0x55 -> rx_data=0x55.
- Assert rx_ack on the exact commit cycle of a second byte 0x0F while holding 0xF0 -> rx_data=0x0F, rx_rdy stays 1, overrun_o=0.
- 5-cycle low glitch on rx_i -> remains IDLE, rx_rdy=0, no error. Frame 0x42 with stop=0 and line held low 40 bits -> exactly one frame_err_o pulse, no commit; line high, then 0x42 -> received correctly.
- Async reset asserted mid-DATA of 0xFF, released with line high -> rx_rdy=0, rx_data=0; the following 0x99 is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> accepted. 0x07 with parity bit 0 -> parity_err_o pulse, rx_rdy stays 0.

Source files
------------

// File: rtl/uart_rx_si_pkg.sv
// Shared types and defaults for the uart_rx_si receiver.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
package uart_rx_si_pkg;

   // Default divider used by the top level when no override is given.
   localparam int UART_BAUD_DIV = 104;

   // Receiver state encoding (3-bit, fixed values).
   typedef enum logic [2:0] {
      URX_IDLE   = 3'd0,
      URX_START  = 3'd1,
      URX_DATA   = 3'd2,
      URX_PARITY = 3'd3,
      URX_STOP   = 3'd4,
      URX_BREAK  = 3'd5
   } urx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable
// reset value so idle-high lines do not glitch low out of reset.
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two register stages; reset forces the idle value into both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_si.sv
// UART 8N1 receiver with a single-entry rx_data/rx_rdy/rx_ack holding
// register and one-cycle frame / overrun error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err_o.
module uart_rx_si
   import uart_rx_si_pkg::*;
#(
   parameter int RX_DATA_WIDTH = 8,
   parameter int BAUD_DIV      = UART_BAUD_DIV
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_i,
   output logic [RX_DATA_WIDTH-1:0] rx_data,
   output logic                     rx_rdy,
   input  logic                     rx_ack,
   output logic                     frame_err_o,
`ifdef UART_RX_PARITY_EN
   output logic                     parity_err_o,
`endif
   output logic                     overrun_o
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(RX_DATA_WIDTH + 1);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(RX_DATA_WIDTH - 1);

   urx_state_e               state, state_nx;
   logic [CW-1:0]            baud_cnt, baud_nx;
   logic [BW-1:0]            bit_cnt, bit_nx;
   logic [RX_DATA_WIDTH-1:0] shreg, shreg_nx;
   logic                     commit_q, commit_nx;
   logic                     ferr_nx;
   logic                     rx_s;
`ifdef UART_RX_PARITY_EN
   logic                     par_bad, par_bad_nx;
   logic                     perr_nx;
`endif

   sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_i),
      .q   (rx_s)
   );

   // FSM and datapath registers; commit is registered so the holding
   // register loads one cycle after the stop sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= URX_IDLE;
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         commit_q     <= 1'b0;
         frame_err_o  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad      <= 1'b0;
         parity_err_o <= 1'b0;
`endif
      end else begin
         state        <= state_nx;
         baud_cnt     <= baud_nx;
         bit_cnt      <= bit_nx;
         shreg        <= shreg_nx;
         commit_q     <= commit_nx;
         frame_err_o  <= ferr_nx;
`ifdef UART_RX_PARITY_EN
         par_bad      <= par_bad_nx;
         parity_err_o <= perr_nx;
`endif
      end
   end

   // Next-state: bit timing, deserialisation and stop/parity checks.
   always_comb begin
      state_nx   = state;
      baud_nx    = baud_cnt + CW'(1);
      bit_nx     = bit_cnt;
      shreg_nx   = shreg;
      commit_nx  = 1'b0;
      ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nx = par_bad;
      perr_nx    = 1'b0;
`endif
      case (state)
         URX_IDLE: begin
            baud_nx = '0;
            bit_nx  = '0;
            if (!rx_s) state_nx = URX_START;
         end
         URX_START: begin
            // Mid start bit: a high line here was only a glitch.
            if (baud_cnt == BAUD_HALF) begin
               baud_nx  = '0;
               bit_nx   = '0;
               state_nx = rx_s ? URX_IDLE : URX_DATA;
            end
         end
         URX_DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_nx  = '0;
               shreg_nx = {rx_s, shreg[RX_DATA_WIDTH-1:1]};
               bit_nx   = bit_cnt + BW'(1);
               if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_nx = URX_PARITY;
`else
                  state_nx = URX_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         URX_PARITY: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_nx    = '0;
               par_bad_nx = ^shreg ^ rx_s;
               state_nx   = URX_STOP;
            end
         end
`endif
         URX_STOP: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_nx = '0;
               if (!rx_s) begin
                  // Frame error wins over parity; the line may be in break.
                  ferr_nx  = 1'b1;
                  state_nx = URX_BREAK;
               end else begin
                  state_nx = URX_IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) perr_nx = 1'b1;
                  else         commit_nx = 1'b1;
`else
                  commit_nx = 1'b1;
`endif
               end
            end
         end
         URX_BREAK: begin
            // Wait for the line to return high so a held-low line
            // reports only one frame error.
            baud_nx = '0;
            if (rx_s) state_nx = URX_IDLE;
         end
         default: begin
            baud_nx  = '0;
            state_nx = URX_IDLE;
         end
      endcase
   end

   // Holding register: load on commit if empty or being acked in the
   // same cycle, otherwise drop the new byte and flag overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data   <= '0;
         rx_rdy    <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         overrun_o <= 1'b0;
         if (commit_q) begin
            if (!rx_rdy || rx_ack) begin
               rx_data <= shreg;
               rx_rdy  <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (rx_ack) begin
            rx_rdy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_si.sv
// Self-checking bench for uart_rx_si (BAUD_DIV=16). Define
// UART_RX_PARITY_EN on both bench and RTL to cover the parity frame.
module tb_uart_rx_si;

   localparam int BAUD = 16;
   localparam int N    = 8;
`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // Edge on which the stop bit is judged, counted from the edge after
   // which the start bit was driven: 2 sync stages, 1 idle detect, half a
   // bit to the start centre, then data (+parity) and stop bits.
   localparam int STOP_OFS = 2 + 1 + BAUD / 2 + BAUD * (N + PB + 1);

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         rx_i = 1'b1;
   logic         rx_ack = 1'b0;
   logic [N-1:0] rx_data;
   logic         rx_rdy, frame_err_o, overrun_o;
`ifdef UART_RX_PARITY_EN
   logic         parity_err_o;
   int           pe_cnt = 0, pe_cyc = 0;
`endif

   int cyc = 0;
   int n_cmp = 0, n_bad = 0;
   int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
   int fe_cyc = 0, ov_cyc = 0, rise_cyc = 0;
   logic rdy_prev = 1'b0;

   uart_rx_si #(.RX_DATA_WIDTH(N), .BAUD_DIV(BAUD)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (rx_i),
      .rx_data     (rx_data),
      .rx_rdy      (rx_rdy),
      .rx_ack      (rx_ack),
      .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
      .parity_err_o(parity_err_o),
`endif
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Pulse and edge monitor sampled mid-cycle.
   always @(negedge clk) begin
      if (frame_err_o) begin fe_cnt++; fe_cyc = cyc; end
      if (overrun_o)   begin ov_cnt++; ov_cyc = cyc; end
      if (frame_err_o && overrun_o) both_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err_o) begin pe_cnt++; pe_cyc = cyc; end
      if (parity_err_o && (frame_err_o || overrun_o)) both_cnt++;
`endif
      if (rx_rdy && !rdy_prev) rise_cyc = cyc;
      rdy_prev = rx_rdy;
   end

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic bit_time(input logic v);
      rx_i = v;
      repeat (BAUD) begin @(posedge clk); #1; end
   endtask

   // Serial frame per the line format; p is the edge count at the start bit.
   task automatic send_frame(input logic [N-1:0] d, input logic stop,
                             input logic par_flip, output int p);
      p = cyc;
      bit_time(1'b0);
      for (int i = 0; i < N; i++) bit_time(d[i]);
      if (PB == 1) bit_time((^d) ^ par_flip);
      bit_time(stop);
   endtask

   task automatic ack_pulse();
      rx_ack = 1'b1;
      @(posedge clk); #1;
      rx_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got=%b exp=0", rx_rdy); end
      n_cmp++; if (rx_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      n_cmp++; if ({frame_err_o, overrun_o} !== 2'b00) begin n_bad++; $display("FAIL reset_err got=%b exp=00", {frame_err_o, overrun_o}); end
      rst = 1'b1;
      idle(20);
   endtask

   task automatic test_basic();
      int p;
      send_frame(8'hA5, 1'b1, 1'b0, p);
      idle(4);
      n_cmp++; if (rx_rdy !== 1'b1) begin n_bad++; $display("FAIL basic_rdy got=%b exp=1", rx_rdy); end
      n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data got=%h exp=a5", rx_data); end
      n_cmp++; if (rise_cyc !== p + STOP_OFS + 1) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", rise_cyc - p, STOP_OFS + 1); end
      n_cmp++; if (fe_cnt + ov_cnt !== 0) begin n_bad++; $display("FAIL basic_errs got=%0d exp=0", fe_cnt + ov_cnt); end
      ack_pulse();
      n_cmp++; if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL ack_clears got=%b exp=0", rx_rdy); end
      n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL ack_data_hold got=%h exp=a5", rx_data); end
   endtask

   task automatic test_overrun();
      int p1, p2, ov0;
      ov0 = ov_cnt;
      send_frame(8'h3C, 1'b1, 1'b0, p1);
      send_frame(8'h81, 1'b1, 1'b0, p2);
      idle(4);
      n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL ovr_keep_old got=%h exp=3c", rx_data); end
      n_cmp++; if (ov_cnt - ov0 !== 1) begin n_bad++; $display("FAIL ovr_count got=%0d exp=1", ov_cnt - ov0); end
      n_cmp++; if (ov_cyc !== p2 + STOP_OFS + 1) begin n_bad++; $display("FAIL ovr_time got=%0d exp=%0d", ov_cyc - p2, STOP_OFS + 1); end
      ack_pulse();
      idle(3);
      send_frame(8'h55, 1'b1, 1'b0, p1);
      idle(4);
      n_cmp++; if (rx_data !== 8'h55 || rx_rdy !== 1'b1) begin n_bad++; $display("FAIL ovr_after_ack got=%h/%b exp=55/1", rx_data, rx_rdy); end
   endtask

   task automatic test_ack_on_commit();
      int p, p0, ov0;
      ack_pulse();
      send_frame(8'hF0, 1'b1, 1'b0, p);
      idle(2);
      n_cmp++; if (rx_data !== 8'hF0) begin n_bad++; $display("FAIL aoc_first got=%h exp=f0", rx_data); end
      ov0 = ov_cnt;
      p0 = cyc;
      fork
         send_frame(8'h0F, 1'b1, 1'b0, p);
         begin
            while (cyc < p0 + STOP_OFS) begin @(posedge clk); #1; end
            ack_pulse();
         end
      join
      idle(2);
      n_cmp++; if (rx_data !== 8'h0F || rx_rdy !== 1'b1) begin n_bad++; $display("FAIL aoc_load got=%h/%b exp=0f/1", rx_data, rx_rdy); end
      n_cmp++; if (ov_cnt !== ov0) begin n_bad++; $display("FAIL aoc_no_overrun got=%0d exp=%0d", ov_cnt, ov0); end
      ack_pulse();
   endtask

   task automatic test_glitch_break();
      int p, fe0;
      fe0 = fe_cnt;
      rx_i = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      idle(3 * BAUD);
      n_cmp++; if (rx_rdy !== 1'b0 || fe_cnt !== fe0) begin n_bad++; $display("FAIL glitch got=%b/%0d exp=0/%0d", rx_rdy, fe_cnt, fe0); end
      send_frame(8'h42, 1'b0, 1'b0, p);
      repeat (40 * BAUD) begin @(posedge clk); #1; end
      n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL break_one_pulse got=%0d exp=1", fe_cnt - fe0); end
      n_cmp++; if (fe_cyc !== p + STOP_OFS) begin n_bad++; $display("FAIL ferr_time got=%0d exp=%0d", fe_cyc - p, STOP_OFS); end
      n_cmp++; if (rx_rdy !== 1'b0) begin n_bad++; $display("FAIL break_no_commit got=%b exp=0", rx_rdy); end
      idle(2 * BAUD);
      send_frame(8'h42, 1'b1, 1'b0, p);
      idle(4);
      n_cmp++; if (rx_data !== 8'h42 || rx_rdy !== 1'b1) begin n_bad++; $display("FAIL after_break got=%h/%b exp=42/1", rx_data, rx_rdy); end
      n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL after_break_ferr got=%0d exp=1", fe_cnt - fe0); end
   endtask

   task automatic test_reset_midframe();
      int p;
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b1);
      #3 rst = 1'b0;
      #1;
      n_cmp++; if (rx_rdy !== 1'b0 || rx_data !== '0) begin n_bad++; $display("FAIL async_reset got=%b/%h exp=0/00", rx_rdy, rx_data); end
      @(posedge clk); #1;
      rst = 1'b1;
      idle(2 * BAUD);
      n_cmp++; if (rx_rdy !== 1'b0 || rx_data !== '0) begin n_bad++; $display("FAIL post_reset got=%b/%h exp=0/00", rx_rdy, rx_data); end
      send_frame(8'h99, 1'b1, 1'b0, p);
      idle(4);
      n_cmp++; if (rx_data !== 8'h99 || rise_cyc !== p + STOP_OFS + 1) begin n_bad++; $display("FAIL reset_recover got=%h@%0d exp=99@%0d", rx_data, rise_cyc - p, STOP_OFS + 1); end
      ack_pulse();
   endtask

   // Random bytes, gaps and acks against a one-entry holding model.
   task automatic test_random();
      logic         exp_rdy;
      logic [N-1:0] exp_data, d;
      int           exp_ov, fe0, p;
      exp_rdy  = rx_rdy;
      exp_data = rx_data;
      exp_ov   = ov_cnt;
      fe0      = fe_cnt;
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 2) == 0) begin ack_pulse(); exp_rdy = 1'b0; end
         idle($urandom_range(0, 3 * BAUD));
         d = N'($urandom);
         send_frame(d, 1'b1, 1'b0, p);
         idle(2);
         if (!exp_rdy) begin exp_data = d; exp_rdy = 1'b1; end
         else exp_ov++;
         n_cmp++;
         if (rx_rdy !== exp_rdy || rx_data !== exp_data || ov_cnt !== exp_ov) begin
            n_bad++;
            $display("FAIL random_%0d got=%b/%h/%0d exp=%b/%h/%0d", k, rx_rdy, rx_data, ov_cnt, exp_rdy, exp_data, exp_ov);
         end
      end
      n_cmp++; if (fe_cnt !== fe0) begin n_bad++; $display("FAIL random_ferr got=%0d exp=%0d", fe_cnt, fe0); end
      ack_pulse();
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int p, pe0, fe0;
      pe0 = pe_cnt;
      fe0 = fe_cnt;
      idle(4);
      send_frame(8'h07, 1'b1, 1'b0, p);
      idle(4);
      n_cmp++; if (rx_data !== 8'h07 || rx_rdy !== 1'b1 || pe_cnt !== pe0) begin n_bad++; $display("FAIL parity_ok got=%h/%b/%0d exp=07/1/%0d", rx_data, rx_rdy, pe_cnt, pe0); end
      ack_pulse();
      send_frame(8'h07, 1'b1, 1'b1, p);
      idle(4);
      n_cmp++; if (pe_cnt - pe0 !== 1 || pe_cyc !== p + STOP_OFS) begin n_bad++; $display("FAIL parity_err got=%0d@%0d exp=1@%0d", pe_cnt - pe0, pe_cyc - p, STOP_OFS); end
      n_cmp++; if (rx_rdy !== 1'b0 || fe_cnt !== fe0) begin n_bad++; $display("FAIL parity_drop got=%b/%0d exp=0/%0d", rx_rdy, fe_cnt, fe0); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_ack_on_commit();
      test_glitch_break();
      test_random();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      // Leaves a byte held so the reset clearing is observable.
      begin
         int p;
         send_frame(8'h6E, 1'b1, 1'b0, p);
         idle(4);
      end
      n_cmp++; if (rx_rdy !== 1'b1) begin n_bad++; $display("FAIL preload_rdy got=%b exp=1", rx_rdy); end
      test_reset_midframe();
      n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
